// File: rtl/cmd_queue_if.sv
// rtl/cmd_queue_if.sv - UART-side command/response and consumer-side handshake bundle for cmd_queue
interface cmd_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [15:0]   cmd_in;
    logic          cmd_rdy;
    logic          clr_cmd_rdy;
    logic [15:0]   cmd;
    logic          cmd_vld;
    logic          cmd_pop;
    logic          cmd_done;
    logic [7:0]    resp;
    logic          trmt;
    logic          tx_done;
    logic [CW-1:0] count;
    logic          overflow;

    modport slave (
        input  cmd_in, cmd_rdy, cmd_pop, cmd_done, tx_done,
        output clr_cmd_rdy, cmd, cmd_vld, resp, trmt, count, overflow
    );

    modport master (
        output cmd_in, cmd_rdy, cmd_pop, cmd_done, tx_done,
        input  clr_cmd_rdy, cmd, cmd_vld, resp, trmt, count, overflow
    );
endinterface

// File: rtl/cmd_queue.sv
// rtl/cmd_queue.sv - command FIFO between UART_wrapper and command processor with ACK/NACK responder
module cmd_queue #(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] ACK_RESP  = 8'hA5,
    parameter logic [7:0] NACK_RESP = 8'hEE
) (
    input  logic      clk,
    input  logic      rst,
    cmd_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = PW + 2;

    typedef enum logic [1:0] {S_IDLE, S_TRMT, S_WAIT} state_t;

    logic [15:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_clr_cmd_rdy;
    logic          r_cap_vld;
    logic [15:0]   r_cap_data;
    logic          r_overflow;
    logic [RW-1:0] r_ack_cnt;
    logic [RW-1:0] r_nack_cnt;
    logic [7:0]    r_resp;
    logic          r_trmt;
    state_t        r_state;

    logic   w_capture;
    logic   w_full;
    logic   w_pop;
    logic   w_push;
    logic   w_drop;
    logic   w_ld_ack;
    logic   w_ld_nack;
    state_t w_next;

    // The guard keeps the still-high cmd_rdy from re-capturing during the clear cycle.
    assign w_capture = bus.cmd_rdy && !r_clr_cmd_rdy;
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = bus.cmd_pop && (r_count != '0);
    // The staged command is stored one cycle after capture; a pop in that cycle frees a full slot.
    assign w_push    = r_cap_vld && (!w_full || w_pop);
    assign w_drop    = r_cap_vld && w_full && !w_pop;

    function automatic logic [RW-1:0] upd_cnt(input logic [RW-1:0] cnt,
                                              input logic inc, input logic dec);
        logic [RW-1:0] res;
        res = cnt;
        if (inc && !dec && (cnt != {RW{1'b1}}))
            res = cnt + RW'(1);
        else if (dec && !inc)
            res = cnt - RW'(1);
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= r_cap_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_clr_cmd_rdy <= 1'b0;
            r_cap_vld     <= 1'b0;
            r_cap_data    <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_clr_cmd_rdy <= w_capture;
            r_cap_vld     <= w_capture;
            if (w_capture)
                r_cap_data <= bus.cmd_in;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_ld_ack  = 1'b0;
        w_ld_nack = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_nack_cnt != '0) begin
                    w_ld_nack = 1'b1;
                    w_next    = S_TRMT;
                end else if (r_ack_cnt != '0) begin
                    w_ld_ack = 1'b1;
                    w_next   = S_TRMT;
                end
            end
            // tx_done may still be high from the previous byte, so it is ignored here.
            S_TRMT:  w_next = S_WAIT;
            S_WAIT:  if (bus.tx_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_trmt     <= 1'b0;
            r_resp     <= 8'h00;
            r_ack_cnt  <= '0;
            r_nack_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_trmt     <= (w_next == S_TRMT);
            if (w_ld_nack)
                r_resp <= NACK_RESP;
            else if (w_ld_ack)
                r_resp <= ACK_RESP;
            r_ack_cnt  <= upd_cnt(r_ack_cnt, bus.cmd_done, w_ld_ack);
            r_nack_cnt <= upd_cnt(r_nack_cnt, w_drop, w_ld_nack);
        end
    end

    assign bus.clr_cmd_rdy = r_clr_cmd_rdy;
    assign bus.cmd         = r_mem[r_rd_ptr];
    assign bus.cmd_vld     = (r_count != '0);
    assign bus.count       = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.resp        = r_resp;
    assign bus.trmt        = r_trmt;
endmodule

// File: tb/tb_cmd_queue.sv
// tb/tb_cmd_queue.sv - directed self-checking bench for cmd_queue
module tb_cmd_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    cmd_queue_if #(.DEPTH(4)) bus ();

    cmd_queue #(.DEPTH(4), .ACK_RESP(8'hA5), .NACK_RESP(8'hEE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // UART-style delivery: cmd_rdy stays high through the clr cycle, then drops.
    task automatic send_cmd(input logic [15:0] d);
        bus.cmd_in  = d;
        bus.cmd_rdy = 1'b1;
        tick();
        bus.cmd_rdy = 1'b1;
        tick();
        bus.cmd_rdy = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [15:0] exp);
        chk(tag, 32'(bus.cmd), 32'(exp));
        bus.cmd_pop = 1'b1;
        tick();
        bus.cmd_pop = 1'b0;
    endtask

    initial begin
        bus.cmd_in   = 16'h0000;
        bus.cmd_rdy  = 1'b0;
        bus.cmd_pop  = 1'b0;
        bus.cmd_done = 1'b0;
        bus.tx_done  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_vld", 32'(bus.cmd_vld), 32'd0);
        chk("rst_clr", 32'(bus.clr_cmd_rdy), 32'd0);
        chk("rst_trmt", 32'(bus.trmt), 32'd0);
        chk("rst_resp", 32'(bus.resp), 32'h00);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);

        // single capture, latency and no double capture
        bus.cmd_in  = 16'h14FE;
        bus.cmd_rdy = 1'b1;
        tick();
        chk("t1_clr_hi", 32'(bus.clr_cmd_rdy), 32'd1);
        chk("t1_vld_early", 32'(bus.cmd_vld), 32'd0);
        tick();
        bus.cmd_rdy = 1'b0;
        chk("t1_clr_lo", 32'(bus.clr_cmd_rdy), 32'd0);
        chk("t1_vld", 32'(bus.cmd_vld), 32'd1);
        chk("t1_cmd", 32'(bus.cmd), 32'h14FE);
        chk("t1_count", 32'(bus.count), 32'd1);
        tick();
        chk("t1_nodouble", 32'(bus.count), 32'd1);
        chk("t1_clr_once", 32'(bus.clr_cmd_rdy), 32'd0);
        pop_chk("t1_pop", 16'h14FE);
        chk("t1_empty", 32'(bus.cmd_vld), 32'd0);

        // fill to four, fifth is dropped and NACKed
        send_cmd(16'h265D);
        send_cmd(16'h3967);
        send_cmd(16'h1111);
        send_cmd(16'h2222);
        chk("t2_full", 32'(bus.count), 32'd4);
        chk("t2_ovf0", 32'(bus.overflow), 32'd0);
        send_cmd(16'h3333);
        chk("t2_drop_count", 32'(bus.count), 32'd4);
        chk("t2_ovf1", 32'(bus.overflow), 32'd1);
        tick();
        chk("t2_trmt", 32'(bus.trmt), 32'd1);
        chk("t2_resp", 32'(bus.resp), 32'hEE);
        tick();
        chk("t2_trmt_off", 32'(bus.trmt), 32'd0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        tick();
        chk("t2_single_nack", 32'(bus.trmt), 32'd0);
        chk("t2_resp_hold", 32'(bus.resp), 32'hEE);
        pop_chk("t2_pop0", 16'h265D);
        pop_chk("t2_pop1", 16'h3967);
        pop_chk("t2_pop2", 16'h1111);
        pop_chk("t2_pop3", 16'h2222);
        chk("t2_drained", 32'(bus.count), 32'd0);
        bus.cmd_pop = 1'b1;
        tick();
        bus.cmd_pop = 1'b0;
        chk("t2_pop_empty", 32'(bus.count), 32'd0);

        // full queue, push coincides with pop
        send_cmd(16'hA001);
        send_cmd(16'hA002);
        send_cmd(16'hA003);
        send_cmd(16'hA004);
        bus.cmd_in  = 16'hBBBB;
        bus.cmd_rdy = 1'b1;
        tick();
        bus.cmd_pop = 1'b1;
        tick();
        bus.cmd_pop = 1'b0;
        bus.cmd_rdy = 1'b0;
        chk("t3_count", 32'(bus.count), 32'd4);
        chk("t3_head", 32'(bus.cmd), 32'hA002);
        tick();
        chk("t3_no_nack", 32'(bus.trmt), 32'd0);
        chk("t3_ovf_sticky", 32'(bus.overflow), 32'd1);
        pop_chk("t3_pop0", 16'hA002);
        pop_chk("t3_pop1", 16'hA003);
        pop_chk("t3_pop2", 16'hA004);
        pop_chk("t3_pop3", 16'hBBBB);

        // two ACKs back-to-back, stale tx_done during TRMT
        bus.cmd_done = 1'b1;
        tick();
        tick();
        bus.cmd_done = 1'b0;
        chk("t4_trmt1", 32'(bus.trmt), 32'd1);
        chk("t4_resp1", 32'(bus.resp), 32'hA5);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("t4_wait_a", 32'(bus.trmt), 32'd0);
        tick();
        chk("t4_wait_b", 32'(bus.trmt), 32'd0);
        tick();
        chk("t4_wait_c", 32'(bus.trmt), 32'd0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        chk("t4_idle", 32'(bus.trmt), 32'd0);
        tick();
        chk("t4_trmt2", 32'(bus.trmt), 32'd1);
        chk("t4_resp2", 32'(bus.resp), 32'hA5);
        tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        tick();
        chk("t4_no_third", 32'(bus.trmt), 32'd0);

        // drop and cmd_done together: NACK wins, ACK follows
        send_cmd(16'hC001);
        send_cmd(16'hC002);
        send_cmd(16'hC003);
        send_cmd(16'hC004);
        bus.cmd_in  = 16'hDDDD;
        bus.cmd_rdy = 1'b1;
        tick();
        bus.cmd_done = 1'b1;
        tick();
        bus.cmd_done = 1'b0;
        bus.cmd_rdy  = 1'b0;
        tick();
        chk("t5_trmt_n", 32'(bus.trmt), 32'd1);
        chk("t5_resp_n", 32'(bus.resp), 32'hEE);
        tick();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        tick();
        chk("t5_trmt_a", 32'(bus.trmt), 32'd1);
        chk("t5_resp_a", 32'(bus.resp), 32'hA5);
        tick();
        chk("t5_in_wait", 32'(bus.trmt), 32'd0);

        // reset while waiting on tx_done with two entries and a pending ACK
        bus.cmd_pop = 1'b1;
        tick();
        tick();
        bus.cmd_pop = 1'b0;
        chk("t6_two", 32'(bus.count), 32'd2);
        bus.cmd_done = 1'b1;
        tick();
        bus.cmd_done = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_count", 32'(bus.count), 32'd0);
        chk("t6_vld", 32'(bus.cmd_vld), 32'd0);
        chk("t6_trmt", 32'(bus.trmt), 32'd0);
        chk("t6_resp", 32'(bus.resp), 32'h00);
        chk("t6_ovf", 32'(bus.overflow), 32'd0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_quiet", 32'(bus.trmt), 32'd0);
        end
        chk("t6_resp_quiet", 32'(bus.resp), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
